// File: rtl/muldiv_pkg.sv
// Shared encodings for the RV32M multiply/divide unit: funct3 opcodes and FSM states.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } op_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_BUSY = 2'd1,
        DIV_BUSY = 2'd2,
        DIV_FIX  = 2'd3
    } state_e;

endpackage

// File: rtl/div_iter.sv
// Restoring divider datapath on unsigned magnitudes, BITS quotient bits per step.
module div_iter #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned BITS  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic             step_i,
    input  logic [WIDTH-1:0] a_mag_i,
    input  logic [WIDTH-1:0] b_mag_i,
    output logic [WIDTH-1:0] quo_o,
    output logic [WIDTH-1:0] rem_o
);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH:0]   r;
    logic [WIDTH-1:0] q;

    // A load already performs the first step from the fresh operands.
    always_comb begin
        r     = load_i ? '0 : {1'b0, rem_q};
        q     = load_i ? a_mag_i : quo_q;
        dvs_d = load_i ? b_mag_i : dvs_q;
        for (int unsigned i = 0; i < BITS; i++) begin
            r = {r[WIDTH-1:0], q[WIDTH-1]};
            q = {q[WIDTH-2:0], 1'b0};
            if (r >= {1'b0, dvs_d}) begin
                r    = r - {1'b0, dvs_d};
                q[0] = 1'b1;
            end
        end
        rem_d = r[WIDTH-1:0];
        quo_d = q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
        end else if (load_i || step_i) begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
        end
    end

    assign quo_o = quo_q;
    assign rem_o = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M multiply/divide unit: latency-counted multiplier, iterative divider.
// Optional MULDIV_EARLY_OUT_EN finishes divide-by-zero/overflow one cycle after acceptance.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH              = 32,
    parameter int unsigned DIV_BITS_PER_CYCLE = 1,
    parameter int unsigned MUL_STAGES         = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs1_val,
    input  logic [WIDTH-1:0] rs2_val,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned      ITERS    = WIDTH / DIV_BITS_PER_CYCLE;
    localparam int unsigned      CNT_W    = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    state_e           state_q;
    op_e              op_q;
    logic [WIDTH-1:0] a_q, b_q, result_q;
    logic             qneg_q, rneg_q, div0_q, ovf_q, done_q;
    logic [CNT_W-1:0] cnt_q;

    op_e              op_in;
    logic             accept, in_signed, neg_a, neg_b, div0_in, ovf_in, early_hit;
    logic [WIDTH-1:0] a_mag, b_mag, early_res;

    always_comb begin
        op_in     = op_e'(op);
        accept    = (state_q == IDLE) && start && !flush && !done_q;
        in_signed = (op_in == OP_DIV) || (op_in == OP_REM);
        neg_a     = in_signed & rs1_val[WIDTH-1];
        neg_b     = in_signed & rs2_val[WIDTH-1];
        a_mag     = neg_a ? -rs1_val : rs1_val;
        b_mag     = neg_b ? -rs2_val : rs2_val;
        div0_in   = (rs2_val == '0);
        ovf_in    = in_signed && (rs1_val == MOST_NEG) && (rs2_val == '1);
        if ((op_in == OP_REM) || (op_in == OP_REMU))
            early_res = div0_in ? rs1_val : '0;
        else
            early_res = div0_in ? '1 : rs1_val;
`ifdef MULDIV_EARLY_OUT_EN
        early_hit = div0_in | ovf_in;
`else
        early_hit = 1'b0;
`endif
    end

    // With a single stage the product is taken straight from the request inputs.
    op_e                mul_op;
    logic [WIDTH-1:0]   mul_a, mul_b, mul_res;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod;
    logic               a_sx, b_sx;

    always_comb begin
        mul_op  = (state_q == IDLE) ? op_in : op_q;
        mul_a   = (state_q == IDLE) ? rs1_val : a_q;
        mul_b   = (state_q == IDLE) ? rs2_val : b_q;
        a_sx    = (mul_op == OP_MULH) || (mul_op == OP_MULHSU);
        b_sx    = (mul_op == OP_MULH);
        a_ext   = {{WIDTH{a_sx & mul_a[WIDTH-1]}}, mul_a};
        b_ext   = {{WIDTH{b_sx & mul_b[WIDTH-1]}}, mul_b};
        prod    = a_ext * b_ext;
        mul_res = (mul_op == OP_MUL) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
    end

    logic [WIDTH-1:0] quo, rem, div_res;
    logic             is_rem_q;

    div_iter #(
        .WIDTH (WIDTH),
        .BITS  (DIV_BITS_PER_CYCLE)
    ) u_div_iter (
        .clk_i   (clk),
        .rst_i   (rst),
        .load_i  (accept && op[2]),
        .step_i  ((state_q == DIV_BUSY) && !flush),
        .a_mag_i (a_mag),
        .b_mag_i (b_mag),
        .quo_o   (quo),
        .rem_o   (rem)
    );

    always_comb begin
        is_rem_q = (op_q == OP_REM) || (op_q == OP_REMU);
        if (div0_q)
            div_res = is_rem_q ? a_q : '1;
        else if (ovf_q)
            div_res = is_rem_q ? '0 : a_q;
        else if (is_rem_q)
            div_res = rneg_q ? -rem : rem;
        else
            div_res = qneg_q ? -quo : quo;
    end

    // The load edge runs the first divide step, so DIV_BUSY covers ITERS-1 steps.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= OP_MUL;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            div0_q   <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            done_q <= 1'b0;
            if (flush) begin
                state_q <= IDLE;
            end else begin
                case (state_q)
                    IDLE: if (accept) begin
                        op_q   <= op_in;
                        a_q    <= rs1_val;
                        b_q    <= rs2_val;
                        qneg_q <= neg_a ^ neg_b;
                        rneg_q <= neg_a;
                        div0_q <= div0_in;
                        ovf_q  <= ovf_in;
                        if (!op[2]) begin
                            if (MUL_STAGES == 1) begin
                                result_q <= mul_res;
                                done_q   <= 1'b1;
                            end else begin
                                state_q <= MUL_BUSY;
                                cnt_q   <= CNT_W'(MUL_STAGES - 2);
                            end
                        end else if (early_hit) begin
                            result_q <= early_res;
                            done_q   <= 1'b1;
                        end else begin
                            state_q <= DIV_BUSY;
                            cnt_q   <= CNT_W'(ITERS - 2);
                        end
                    end
                    MUL_BUSY: begin
                        if (cnt_q == '0) begin
                            result_q <= mul_res;
                            done_q   <= 1'b1;
                            state_q  <= IDLE;
                        end else begin
                            cnt_q <= cnt_q - CNT_W'(1);
                        end
                    end
                    DIV_BUSY: begin
                        if (cnt_q == '0) state_q <= DIV_FIX;
                        else             cnt_q   <= cnt_q - CNT_W'(1);
                    end
                    DIV_FIX: begin
                        result_q <= div_res;
                        done_q   <= 1'b1;
                        state_q  <= IDLE;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = done_q;
    assign result = result_q;

endmodule
